// File: rtl/ham_pkg.sv
// rtl/ham_pkg.sv - shared constants, FSM state and FIFO entry type for the Hamming encode scheduler
package ham_pkg;
    localparam int INFO_W = 12;
    localparam int CW_W = 17;
    // NUM_REQ tops out at 4, so two ID bits always cover the stored requester index
    localparam int ID_FIELD_W = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [ID_FIELD_W-1:0] id;
        logic [CW_W-1:0]       cw;
    } cw_entry_t;
endpackage

// File: rtl/ham_cw_fifo.sv
// rtl/ham_cw_fifo.sv - synchronous FIFO for codeword entries, count held in log2(DEPTH)+1 bits
module ham_cw_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ham_enc.sv
// rtl/ham_enc.sv - combinational Hamming(17,12) encoder, parity at positions 1,2,4,8,16
module ham_enc
    import ham_pkg::*;
(
    input  logic [INFO_W-1:0] info,
    output logic [CW_W-1:0]   codeword
);
    logic [17:1] dpos;
    logic [4:0]  par;

    always_comb begin
        dpos     = '0;
        dpos[3]  = info[0];
        dpos[5]  = info[1];
        dpos[6]  = info[2];
        dpos[7]  = info[3];
        dpos[15:9] = info[10:4];
        dpos[17] = info[11];
        par = '0;
        for (int k = 0; k < 5; k++) begin
            for (int p = 1; p <= 17; p++) begin
                if (p[k]) par[k] = par[k] ^ dpos[p];
            end
        end
    end

    assign codeword = {dpos[17], par[4], dpos[15:9], par[3], dpos[7:5], par[2], dpos[3], par[1], par[0]};
endmodule

// File: rtl/ham_enc_sched.sv
// rtl/ham_enc_sched.sv - round-robin scheduler sharing one Hamming encoder; HAM_ENC_SCHED_STATS_EN adds per-requester transfer counters
module ham_enc_sched
    import ham_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int ID_W       = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enc_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [INFO_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [CW_W-1:0]           out_codeword,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
`ifdef HAM_ENC_SCHED_STATS_EN
    input  logic                      stats_clr,
    output logic [NUM_REQ*16-1:0]     grant_cnt,
`endif
    output logic                      busy
);
    state_t                      state;
    state_t                      state_nxt;
    logic [ID_W-1:0]             rr_ptr;
    logic                        grant_any;
    int                          grant_sel;
    logic [INFO_W-1:0]           sel_info;
    logic [CW_W-1:0]             enc_cw;
    cw_entry_t                   push_entry;
    cw_entry_t                   head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        pop;

    // Search starts one past the last served requester, so the last winner gets lowest priority
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_sel = 0;
        if (state == RUN && enc_en && !fifo_full) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!grant_any && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                    grant_any = 1'b1;
                    grant_sel = (int'(rr_ptr) + k) % NUM_REQ;
                end
            end
        end
        if (grant_any) req_ready[grant_sel] = 1'b1;
    end

    assign sel_info      = req_data[grant_sel*INFO_W +: INFO_W];
    assign push_entry.cw = enc_cw;
    assign push_entry.id = ID_FIELD_W'(grant_sel);

    ham_enc u_enc (
        .info     (sel_info),
        .codeword (enc_cw)
    );

    ham_cw_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cw_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant_any),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid    = !fifo_empty;
    assign out_codeword = head.cw;
    assign out_id       = ID_W'(head.id);
    assign pop          = out_valid && out_ready;
    assign busy         = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (enc_en) state_nxt = RUN;
            RUN:   if (!enc_en) state_nxt = fifo_empty ? IDLE : DRAIN;
            DRAIN: begin
                if (enc_en) state_nxt = RUN;
                else if (fifo_empty || (fifo_count == 1 && pop)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= ID_W'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            if (grant_any) rr_ptr <= ID_W'(grant_sel);
        end
    end

`ifdef HAM_ENC_SCHED_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr) cnt[i] <= '0;
                else if (req_ready[i] && req_valid[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = cnt[g];
    end
`endif
endmodule

// File: tb/tb_ham_enc_sched.sv
// tb/tb_ham_enc_sched.sv - self-checking bench: encoder vector table, directed corner sequences, randomized run against a queue model
module tb_ham_enc_sched;
    localparam int NUM_REQ = 2;
    localparam int DEPTH   = 2;
    localparam int ID_W    = 2;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    enc_en;
    logic [NUM_REQ-1:0]      req_valid;
    logic [12*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    out_valid;
    logic [16:0]             out_codeword;
    logic [ID_W-1:0]         out_id;
    logic                    out_ready;
    logic                    busy;
`ifdef HAM_ENC_SCHED_STATS_EN
    logic                    stats_clr;
    logic [NUM_REQ*16-1:0]   grant_cnt;
`endif

    ham_enc_sched #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enc_en       (enc_en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_codeword (out_codeword),
        .out_id       (out_id),
        .out_ready    (out_ready),
`ifdef HAM_ENC_SCHED_STATS_EN
        .stats_clr    (stats_clr),
        .grant_cnt    (grant_cnt),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [16:0] cw; int id; } ent_t;
    typedef struct { int id; logic [11:0] info; logic [16:0] cw; } vec_t;

    ent_t q[$];
    int   mst;
    int   last_srv;
    int   last_grant;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [16:0] ref_enc(input logic [11:0] info);
        logic [16:0] cw = '0;
        int d = 0;
        for (int p = 1; p <= 17; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = info[d];
                d++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            int pp = 1 << k;
            for (int p = 1; p <= 17; p++)
                if ((p & pp) != 0 && p != pp) cw[pp-1] = cw[pp-1] ^ cw[p-1];
        end
        return cw;
    endfunction

    function automatic int model_grant();
        if (mst != M_RUN || !enc_en || q.size() >= DEPTH) return -1;
        for (int k = 1; k <= NUM_REQ; k++)
            if (req_valid[(last_srv + k) % NUM_REQ]) return (last_srv + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mst = M_IDLE;
        last_srv = NUM_REQ - 1;
    endtask

    // Called at posedge+1 with inputs already driven; checks before the edge, then advances the model
    task automatic cycle();
        int   g;
        bit   do_pop;
        int   sz;
        ent_t e;
        #3;
        g = model_grant();
        chk("req_ready", 32'(req_ready), g >= 0 ? (32'd1 << g) : 32'd0);
        chk("busy", 32'(busy), 32'(mst != M_IDLE));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_codeword", 32'(out_codeword), 32'(q[0].cw));
            chk("out_id", 32'(out_id), 32'(q[0].id));
        end
        last_grant = g;
        sz = q.size();
        do_pop = (sz != 0) && out_ready;
        case (mst)
            M_IDLE:  if (enc_en) mst = M_RUN;
            M_RUN:   if (!enc_en) mst = (sz == 0) ? M_IDLE : M_DRAIN;
            default: if (enc_en) mst = M_RUN;
                     else if (sz == 0 || (sz == 1 && do_pop)) mst = M_IDLE;
        endcase
        if (do_pop) void'(q.pop_front());
        if (g >= 0) begin
            e.cw = ref_enc(req_data[12*g +: 12]);
            e.id = g;
            q.push_back(e);
            last_srv = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_idle();
        req_valid = '0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) cycle();
    endtask

    initial begin
        vec_t tbl[5];
        int   n;
        int   prev;
        bit   got;
        logic [16:0] held;

        tbl[0] = '{0, 12'h001, 17'h00007};
        tbl[1] = '{1, 12'h800, 17'h18001};
        tbl[2] = '{0, 12'hFFF, 17'h1FFFE};
        tbl[3] = '{1, 12'h002, 17'h00019};
        tbl[4] = '{0, 12'h000, 17'h00000};

        rst_n = 1'b0; enc_en = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
`ifdef HAM_ENC_SCHED_STATS_EN
        stats_clr = 1'b0;
`endif
        model_reset();
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_out_codeword", 32'(out_codeword), 0);
        chk("rst_out_id", 32'(out_id), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Encoder vectors through the full path
        enc_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = NUM_REQ'(1 << tbl[i].id);
            req_data  = 24'(tbl[i].info) << (12 * tbl[i].id);
            got = 0;
            for (int t = 0; t < 6 && !got; t++) begin
                cycle();
                got = (last_grant == tbl[i].id);
            end
            chk("table_grant", 32'(got), 1);
            req_valid = '0;
            #2;
            chk("table_valid", 32'(out_valid), 1);
            chk("table_codeword", 32'(out_codeword), 32'(tbl[i].cw));
            chk("table_id", 32'(out_id), 32'(tbl[i].id));
            cycle();
        end

        // Both requesters valid: grants alternate, one per cycle
        req_valid = '1;
        prev = -1;
        for (int t = 0; t < 8; t++) begin
            req_data = 24'($urandom);
            cycle();
            chk("one_per_cycle", 32'(last_grant >= 0), 1);
            if (prev >= 0) chk("alternate", 32'(last_grant), 32'(1 - prev));
            prev = last_grant;
        end

        // Backpressure: exactly DEPTH accepts, head stable
        drain_idle();
        enc_en = 1'b1; out_ready = 1'b0; req_valid = '1;
        n = 0;
        for (int t = 0; t < 6; t++) begin
            req_data = 24'($urandom);
            cycle();
            if (last_grant >= 0) n++;
            if (t == 2) held = out_codeword;
        end
        chk("accepts_when_full", 32'(n), DEPTH);
        chk("head_stable", 32'(out_codeword), 32'(held));
        out_ready = 1'b1;
        n = 0;
        for (int t = 0; t < 6; t++) begin
            cycle();
            if (last_grant >= 0) n++;
        end
        chk("accepts_resume", 32'(n > 0), 1);

        // enc_en drop with a full FIFO: no accepts, drain, then IDLE
        drain_idle();
        enc_en = 1'b1; out_ready = 1'b0; req_valid = '1;
        for (int t = 0; t < 6; t++) cycle();
        enc_en = 1'b0;
        repeat (2) cycle();
        chk("drain_busy", 32'(busy), 1);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("busy_after_drain", 32'(busy), 0);

        // Reset mid-burst with one queued word
        enc_en = 1'b1; out_ready = 1'b0; req_valid = 2'b01;
        got = 0;
        for (int t = 0; t < 6 && !got; t++) begin
            cycle();
            got = (last_grant >= 0);
        end
        chk("pre_reset_grant", 32'(got), 1);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = '1; out_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 6 && !got; t++) begin
            cycle();
            got = (last_grant >= 0);
        end
        chk("first_grant_after_reset", 32'(last_grant), 0);

`ifdef HAM_ENC_SCHED_STATS_EN
        drain_idle();
        stats_clr = 1'b1; cycle(); stats_clr = 1'b0;
        enc_en = 1'b1; req_valid = 2'b01;
        n = 0;
        for (int t = 0; t < 10 && n < 3; t++) begin
            cycle();
            if (last_grant == 0) n++;
        end
        req_valid = '0;
        cycle();
        chk("stats_cnt0", 32'(grant_cnt[15:0]), 3);
        stats_clr = 1'b1; cycle(); stats_clr = 1'b0;
        chk("stats_clear", 32'(grant_cnt), 0);
`endif

        // Randomized traffic against the queue model
        for (int t = 0; t < 400; t++) begin
            enc_en    = ($urandom_range(0, 9) != 0);
            req_valid = NUM_REQ'($urandom);
            req_data  = 24'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ham_enc_sched.md
Name: ham_enc_sched

Overview:
- Round-robin scheduler that shares one 12-bit-to-17-bit Hamming encoder among NUM_REQ requesters.
- Accepts one info word per cycle from the granted requester and encodes it in the accept cycle.
- Queues the codeword with its requester ID in a small output FIFO and presents it on a valid/ready stream.
- Sits between the information-word producers and the channel/serializer stage.

Parameters:
- NUM_REQ, 2, number of requesters; legal values 2..4.
- FIFO_DEPTH, 2, output FIFO entries; power of two, at least 2.
- ID_W, 2, width of the requester ID; must be at least ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enc_en  in  1  enables granting; low stops new accepts and drains the FIFO.
- req_valid  in  NUM_REQ  per-requester valid.
- req_data  in  12*NUM_REQ  info words; requester i uses bits [12*i+11 : 12*i].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- out_valid  out  1  codeword available.
- out_codeword  out  17  encoded word.
- out_id  out  ID_W  index of the requester that supplied the word.
- out_ready  in  1  downstream accept.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset: all state clears asynchronously on rst_n low. FSM=IDLE; FIFO empty; out_valid=0, out_codeword=0, out_id=0, req_ready=0, busy=0. The round-robin pointer resets to NUM_REQ-1, so requester 0 has highest priority first.
- FSM states and transitions:
  - IDLE -> RUN when enc_en=1.
  - RUN -> DRAIN when enc_en=0 and the FIFO is not empty.
  - RUN -> IDLE when enc_en=0 and the FIFO is empty.
  - DRAIN -> RUN when enc_en=1.
  - DRAIN -> IDLE when the FIFO becomes empty, including on the cycle of the last pop.
- Grant condition: state=RUN, enc_en=1 and FIFO not full.
  - Grant goes to the first valid requester after the pointer, searching cyclically.
  - req_ready is one-hot for the granted requester only, combinational from req_valid, state and FIFO count.
  - req_ready never depends on out_ready; there is no combinational path from out_ready.
- Transfer: occurs when req_valid[i] and req_ready[i] are both high.
  - The word is encoded combinationally and pushed with ID=i in the same cycle.
  - The pointer moves to i only on a transfer.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N, with no bubble when the FIFO is empty.
- Output: out_codeword and out_id come from the FIFO head. A pop occurs when out_valid and out_ready are both high.
- Output stability: while out_valid=1 and out_ready=0, out_codeword and out_id must not change.
- FIFO full: no grant, so all req_ready are 0. A pop in that cycle does not enable a same-cycle push; the push happens next cycle.
- FIFO empty: out_valid=0. Data outputs hold their last value and are don't-care to the checker.
- Simultaneous push and pop when not full: the count is unchanged and both operations take effect.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. The count is held in ceil(log2(FIFO_DEPTH))+1 bits.
- enc_en falling mid-stream: any transfer in that cycle has already been gated, since grant requires enc_en=1. Queued words still drain.
- Reset mid-operation: the FIFO contents are discarded with no output.

Optional Feature:
- Macro: HAM_ENC_SCHED_STATS_EN.
- Enabled:
  - Adds output grant_cnt, NUM_REQ*16 bits: one saturating 16-bit transfer counter per requester. Each counter holds at 16'hFFFF.
  - Adds input stats_clr, synchronous. It zeroes all counters and takes priority over a same-cycle increment.
  - Counters reset to 0 on rst_n.
- Disabled: neither port exists and there is no counter logic. All other behaviour is identical.

Decomposition:
- Shared package ham_pkg holds:
  - constants INFO_W=12 and CW_W=17;
  - the FSM state enum (IDLE, RUN, DRAIN);
  - a codeword-plus-ID struct type for the FIFO entry.
- Sub-modules:
  - Instantiate the existing ham_enc combinational encoder once.
  - Put the FIFO in sub-module ham_cw_fifo (sync FIFO, parameterised by depth and entry width).

Test Plan:
- Reset then enc_en=1; req0 sends 12'h001 with out_ready=1 -> next cycle out_valid=1, out_codeword=17'h00007, out_id=0; busy=1.
- req1 sends 12'h800 -> out_codeword=17'h18001, out_id=1.
- Both requesters hold valid continuously with out_ready=1 -> grants alternate 0,1,0,1 and out_id follows the same sequence, one word per cycle.
- out_ready=0 with both requesters valid and FIFO_DEPTH=2 -> exactly 2 accepts, then req_ready=0 and out_codeword stable. Raise out_ready -> words drain in order, then accepts resume.
- Fill 2 words, drop enc_en, keep req_valid high -> no further accepts; FSM goes to DRAIN, then 2 pops, then IDLE and busy=0.
- Assert rst_n=0 mid-burst with the FIFO holding 1 word -> immediately out_valid=0 and busy=0. After release, the first grant goes to requester 0.
- With HAM_ENC_SCHED_STATS_EN defined: 3 transfers from req0 -> that requester's counter reads 3. Pulse stats_clr -> all counters read 0.
